// File: rtl/calc_display_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_display_if
// Brief    : Calculator-to-display bus: digit write port plus LED drive outputs.
// Revision : 1.0
// ============================================================================
interface calc_display_if;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame_done;

    modport master (
        output status, data, pos,
        input  an, seg, frame_done
    );

    modport slave (
        input  status, data, pos,
        output an, seg, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/calc_display.sv
`default_nettype none
// ============================================================================
// Module   : calc_display
// Brief    : Double-buffered 8-digit multiplexed 7-segment driver for a BCD calculator.
// Revision : 1.0
// ============================================================================
module calc_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    calc_display_if.slave      calc_if
);

    localparam int          DIV_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [1:0]  ST_ERROR  = 2'b00;
    localparam logic [1:0]  ST_BUSY   = 2'b01;
    localparam logic [1:0]  ST_READY  = 2'b10;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_E     = 7'b0000110;
    localparam logic [6:0]  SEG_R     = 7'b0101111;

    logic [3:0]       shadow_q [8];
    logic [3:0]       disp_q   [8];
    logic [1:0]       status_q;
    logic             err_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [2:0]       scan_idx_q;
    logic [7:0]       an_q;
    logic [6:0]       seg_q;
    logic             frame_done_q;

    logic             capture;
    logic             commit;
    logic [7:0]       lz;
    logic [7:0]       an_d;
    logic [6:0]       seg_d;

    function automatic logic [6:0] f_dec(input logic [3:0] v);
        case (v)
            4'd0:    f_dec = 7'b1000000;
            4'd1:    f_dec = 7'b1111001;
            4'd2:    f_dec = 7'b0100100;
            4'd3:    f_dec = 7'b0110000;
            4'd4:    f_dec = 7'b0011001;
            4'd5:    f_dec = 7'b0010010;
            4'd6:    f_dec = 7'b0000010;
            4'd7:    f_dec = 7'b1111000;
            4'd8:    f_dec = 7'b0000000;
            4'd9:    f_dec = 7'b0010000;
            default: f_dec = SEG_BLANK;
        endcase
    endfunction

    assign capture = (calc_if.status != ST_READY) && (calc_if.pos[3] == 1'b0);
    assign commit  = (calc_if.status == ST_READY) && (status_q != ST_READY);

    // lz[i] is set when every digit from i up to 7 is zero.
    always_comb begin
        lz = '1;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if ((j >= i) && (disp_q[j] != 4'd0)) begin
                    lz[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        an_d  = ~(8'h01 << scan_idx_q);
        seg_d = f_dec(disp_q[scan_idx_q]);
        if ((BLANK_LZ == 1) && (scan_idx_q != 3'd0) && lz[scan_idx_q]) begin
            seg_d = SEG_BLANK;
        end
        if (err_q) begin
            if (scan_idx_q >= 3'd3) begin
                seg_d = SEG_BLANK;
            end else if (scan_idx_q == 3'd2) begin
                seg_d = SEG_E;
            end else begin
                seg_d = SEG_R;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 4'd0;
                disp_q[i]   <= 4'd0;
            end
            status_q     <= ST_BUSY;
            err_q        <= 1'b0;
            div_cnt_q    <= '0;
            scan_idx_q   <= 3'd0;
            an_q         <= 8'hFF;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            status_q     <= calc_if.status;
            frame_done_q <= commit;

            if (capture) begin
                shadow_q[calc_if.pos[2:0]] <= calc_if.data;
            end
            if (commit) begin
                for (int i = 0; i < 8; i++) begin
                    disp_q[i] <= shadow_q[i];
                end
            end
            if (calc_if.status == ST_ERROR) begin
                err_q <= 1'b1;
            end

            if (div_cnt_q == DIV_LAST) begin
                div_cnt_q  <= '0;
                scan_idx_q <= scan_idx_q + 3'd1;
            end else begin
                div_cnt_q  <= div_cnt_q + 1'b1;
            end

            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign calc_if.an         = an_q;
    assign calc_if.seg        = seg_q;
    assign calc_if.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_display
// Brief    : Directed bench for calc_display; instance A (div 3, blanking) and B (div 2, no blanking).
// Revision : 1.0
// ============================================================================
module tb_calc_display;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    calc_display_if if_a ();
    calc_display_if if_b ();

    calc_display #(.REFRESH_DIV(3), .BLANK_LZ(1)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .calc_if (if_a.slave)
    );

    calc_display #(.REFRESH_DIV(2), .BLANK_LZ(0)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .calc_if (if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
        if_a.status = st; if_a.pos = p; if_a.data = d;
        if_b.status = st; if_b.pos = p; if_b.data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_digit(input logic [3:0] p, input logic [3:0] d);
        set_in(2'b01, p, d);
        tick();
    endtask

    // Raise ready for one edge and expect the frame_done pulse on both instances.
    task automatic commit_frame(input string tag);
        set_in(2'b10, 4'hF, 4'h0);
        tick();
        chk({tag, "_fd_a"}, {7'd0, if_a.frame_done}, 8'd1);
        chk({tag, "_fd_b"}, {7'd0, if_b.frame_done}, 8'd1);
        tick();
        chk({tag, "_fd_a_off"}, {7'd0, if_a.frame_done}, 8'd0);
    endtask

    task automatic check_digit(input bit use_b, input int idx, input logic [6:0] exp, input string tag);
        logic [7:0] tgt;
        logic [7:0] an_now;
        bit         found;
        int         k;
        tgt   = ~(8'h01 << idx);
        found = 1'b0;
        k     = 0;
        while (!found && k < 64) begin
            tick();
            an_now = use_b ? if_b.an : if_a.an;
            if (an_now === tgt) found = 1'b1;
            k++;
        end
        chk({tag, "_scan"}, {7'd0, found}, 8'd1);
        if (found) chk(tag, {1'b0, (use_b ? if_b.seg : if_a.seg)}, {1'b0, exp});
    endtask

    initial begin
        logic [7:0] prev;
        bit         seen;

        set_in(2'b01, 4'hF, 4'h0);
        #12;
        chk("rst_an_a",  if_a.an, 8'hFF);
        chk("rst_seg_a", {1'b0, if_a.seg}, 8'h7F);
        chk("rst_fd_a",  {7'd0, if_a.frame_done}, 8'd0);
        chk("rst_an_b",  if_b.an, 8'hFF);

        // Release reset between edges and follow the scan timing.
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_an_a",  if_a.an, 8'hFE);
        chk("first_seg_a", {1'b0, if_a.seg}, 8'h40);
        chk("first_an_b",  if_b.an, 8'hFE);
        tick();
        tick();
        chk("hold_an_a", if_a.an, 8'hFE);
        tick();
        chk("step_an_a",  if_a.an, 8'hFD);
        chk("blank1_a",   {1'b0, if_a.seg}, 8'h7F);
        chk("step_an_b",  if_b.an, 8'hFD);
        tick();
        chk("step2_an_b", if_b.an, 8'hFB);

        // Frame "124", with an out-of-range write that must be ignored.
        write_digit(4'd0, 4'd4);
        write_digit(4'd1, 4'd2);
        write_digit(4'd2, 4'd1);
        for (int i = 3; i < 8; i++) write_digit(4'(i), 4'd0);
        write_digit(4'd8, 4'd9);
        commit_frame("f124");
        tick();
        chk("no_refire_fd", {7'd0, if_a.frame_done}, 8'd0);
        check_digit(1'b0, 0, 7'b0011001, "f124_d0");
        check_digit(1'b0, 1, 7'b0100100, "f124_d1");
        check_digit(1'b0, 2, 7'b1111001, "f124_d2");
        check_digit(1'b0, 3, 7'b1111111, "f124_d3");
        check_digit(1'b0, 7, 7'b1111111, "f124_d7");

        // Non-BCD value decodes to blank.
        write_digit(4'd0, 4'd12);
        commit_frame("f12");
        check_digit(1'b0, 0, 7'b1111111, "bad_d0");
        check_digit(1'b0, 1, 7'b0100100, "bad_d1");

        // Partial frame discarded by reset.
        for (int i = 0; i < 4; i++) write_digit(4'(i), 4'd9);
        set_in(2'b01, 4'hF, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an", if_a.an, 8'hFF);
        chk("mid_rst_fd", {7'd0, if_a.frame_done}, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_fd", {7'd0, if_a.frame_done}, 8'd0);
        check_digit(1'b0, 1, 7'b1111111, "post_rst_d1");
        commit_frame("fzero");
        check_digit(1'b0, 3, 7'b1111111, "fzero_d3");
        check_digit(1'b0, 0, 7'b1000000, "fzero_d0");

        // Frame 00000007 on both instances.
        write_digit(4'd0, 4'd7);
        for (int i = 1; i < 8; i++) write_digit(4'(i), 4'd0);
        commit_frame("f7");
        check_digit(1'b0, 0, 7'b1111000, "f7_a_d0");
        check_digit(1'b0, 1, 7'b1111111, "f7_a_d1");
        check_digit(1'b1, 0, 7'b1111000, "f7_b_d0");
        check_digit(1'b1, 7, 7'b1000000, "f7_b_d7");
        check_digit(1'b1, 4, 7'b1000000, "f7_b_d4");

        prev = if_b.an;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (if_b.an === 8'hFE && prev !== 8'hFE) seen = 1'b1;
            prev = if_b.an;
        end
        chk("b_enter_fe", {7'd0, seen}, 8'd1);
        tick();
        chk("b_hold_fe", if_b.an, 8'hFE);
        tick();
        chk("b_next_fd", if_b.an, 8'hFD);

        // One-cycle error status latches the Err display.
        set_in(2'b00, 4'hF, 4'h0);
        tick();
        set_in(2'b01, 4'hF, 4'h0);
        check_digit(1'b0, 2, 7'b0000110, "err_d2");
        check_digit(1'b0, 1, 7'b0101111, "err_d1");
        check_digit(1'b0, 0, 7'b0101111, "err_d0");
        check_digit(1'b0, 3, 7'b1111111, "err_d3");
        check_digit(1'b0, 7, 7'b1111111, "err_d7");
        check_digit(1'b1, 2, 7'b0000110, "err_b_d2");
        write_digit(4'd0, 4'd5);
        commit_frame("ferr");
        check_digit(1'b0, 0, 7'b0101111, "err_hold_d0");

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_digit(1'b0, 0, 7'b1000000, "err_clr_d0");
        check_digit(1'b0, 2, 7'b1111111, "err_clr_d2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
